spi_mem_master: RTL and testbench

SPI_MEM_MASTER -- requirements
Module: spi_mem_master

---
 rtl/spi_mem_pkg.sv | 20 ++
 rtl/spi_shift_engine.sv | 83 ++++++++
 rtl/spi_mem_master.sv | 180 ++++++++++++++++++
 tb/tb_spi_mem_master.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_mem_pkg.sv
// Shared types and opcodes for the SPI memory master.
// The FSM states and the command bytes live here.
package spi_mem_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_DATA,
      ST_GAP
   } state_t;

   localparam logic [7:0] OP_READ  = 8'h03;
   localparam logic [7:0] OP_WRITE = 8'h02;

   function automatic logic [7:0] opcode(input logic write);
      return write ? OP_WRITE : OP_READ;
   endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// SPI mode-0 clock divider and 8-bit shifter. Runs one byte at a time and
// either reloads at the byte boundary (load_next) or stops with SCK low.
module spi_shift_engine
   import spi_mem_pkg::*;
#(
   parameter int CLK_DIV = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       load_next,
   input  logic [7:0] tx_byte,
   input  logic       miso,
   output logic       sck,
   output logic       mosi,
   output logic       byte_end,
   output logic       last_sample,
   output logic [7:0] rx_next
);

   localparam int DIV_W = $clog2(CLK_DIV) + 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic             active_reg;
   logic             sck_reg;
   logic [DIV_W-1:0] div_cnt_reg;
   logic [2:0]       bit_cnt_reg;
   logic [7:0]       tx_sh_reg;
   logic [7:0]       rx_sh_reg;
   logic             phase_end;
   logic             rise;
   logic             fall;

   assign phase_end   = active_reg && (div_cnt_reg == DIV_LAST);
   assign rise        = phase_end && !sck_reg;
   assign fall        = phase_end && sck_reg;
   assign byte_end    = fall && (bit_cnt_reg == 3'd7);
   assign last_sample = rise && (bit_cnt_reg == 3'd7);
   assign rx_next     = {rx_sh_reg[6:0], miso};
   assign sck         = sck_reg;
   assign mosi        = active_reg & tx_sh_reg[7];

   // MOSI only moves on the falling-edge cycle; MISO is captured as SCK rises.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_reg  <= 1'b0;
         sck_reg     <= 1'b0;
         div_cnt_reg <= '0;
         bit_cnt_reg <= 3'd0;
         tx_sh_reg   <= 8'h00;
         rx_sh_reg   <= 8'h00;
      end else if (start) begin
         active_reg  <= 1'b1;
         sck_reg     <= 1'b0;
         div_cnt_reg <= '0;
         bit_cnt_reg <= 3'd0;
         tx_sh_reg   <= tx_byte;
         rx_sh_reg   <= 8'h00;
      end else if (active_reg) begin
         div_cnt_reg <= phase_end ? '0 : div_cnt_reg + 1'b1;
         if (rise) begin
            sck_reg   <= 1'b1;
            rx_sh_reg <= rx_next;
         end
         if (fall) begin
            sck_reg <= 1'b0;
            if (bit_cnt_reg == 3'd7) begin
               bit_cnt_reg <= 3'd0;
               if (load_next) begin
                  tx_sh_reg <= tx_byte;
               end else begin
                  active_reg <= 1'b0;
                  tx_sh_reg  <= 8'h00;
               end
            end else begin
               bit_cnt_reg <= bit_cnt_reg + 3'd1;
               tx_sh_reg   <= {tx_sh_reg[6:0], 1'b0};
            end
         end
      end
   end

endmodule

// File: rtl/spi_mem_master.sv
// SPI mode-0 master for serial memories: command, address, then 1..256
// data bytes per request, followed by a CS-high gap of two SCK phases.
module spi_mem_master
   import spi_mem_pkg::*;
#(
   parameter int ADDR_BYTES = 1,
   parameter int CLK_DIV    = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_write,
   input  logic [8*ADDR_BYTES-1:0] req_addr,
   input  logic [7:0]              req_len,
   input  logic [7:0]              wr_data,
   output logic                    wr_ready,
   output logic [7:0]              rd_data,
   output logic                    rd_valid,
   output logic                    busy,
   output logic                    spi_cs_n,
   output logic                    spi_sck,
   output logic                    spi_mosi,
   input  logic                    spi_miso
);

   localparam int GAP_W = $clog2(2 * CLK_DIV) + 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(2 * CLK_DIV - 1);

   state_t                  state_reg;
   state_t                  state_next;
   logic                    write_reg;
   logic [8*ADDR_BYTES-1:0] addr_reg;
   logic [1:0]              addr_idx_reg;
   logic [7:0]              byte_cnt_reg;
   logic [GAP_W-1:0]        gap_cnt_reg;
   logic                    cs_n_reg;
   logic [7:0]              rd_data_reg;
   logic                    rd_valid_reg;
   logic                    wr_ready_reg;
   logic [7:0]              addr_bytes [4];

   logic                    start;
   logic                    load_next;
   logic                    wr_load;
   logic [7:0]              tx_byte;
   logic                    byte_end;
   logic                    last_sample;
   logic [7:0]              rx_next;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_addr
         if (gi < ADDR_BYTES) begin : g_used
            assign addr_bytes[gi] = addr_reg[8*gi +: 8];
         end else begin : g_unused
            assign addr_bytes[gi] = 8'h00;
         end
      end
   endgenerate

   spi_shift_engine #(
      .CLK_DIV (CLK_DIV)
   ) u_engine (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .load_next   (load_next),
      .tx_byte     (tx_byte),
      .miso        (spi_miso),
      .sck         (spi_sck),
      .mosi        (spi_mosi),
      .byte_end    (byte_end),
      .last_sample (last_sample),
      .rx_next     (rx_next)
   );

   // Next byte is chosen on the byte_end cycle so SCK runs without pauses.
   always_comb begin
      state_next = state_reg;
      start      = 1'b0;
      load_next  = 1'b0;
      wr_load    = 1'b0;
      tx_byte    = 8'h00;
      case (state_reg)
         ST_IDLE: begin
            if (req_valid) begin
               start      = 1'b1;
               tx_byte    = opcode(req_write);
               state_next = ST_CMD;
            end
         end
         ST_CMD: begin
            if (byte_end) begin
               load_next  = 1'b1;
               tx_byte    = addr_bytes[2'(ADDR_BYTES - 1)];
               state_next = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (byte_end) begin
               load_next = 1'b1;
               if (addr_idx_reg == 2'd0) begin
                  wr_load    = write_reg;
                  tx_byte    = write_reg ? wr_data : 8'h00;
                  state_next = ST_DATA;
               end else begin
                  tx_byte = addr_bytes[addr_idx_reg - 2'd1];
               end
            end
         end
         ST_DATA: begin
            if (byte_end) begin
               if (byte_cnt_reg == 8'd0) begin
                  state_next = ST_GAP;
               end else begin
                  load_next = 1'b1;
                  wr_load   = write_reg;
                  tx_byte   = write_reg ? wr_data : 8'h00;
               end
            end
         end
         ST_GAP: begin
            if (gap_cnt_reg == GAP_LAST) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         write_reg    <= 1'b0;
         addr_reg     <= '0;
         addr_idx_reg <= 2'd0;
         byte_cnt_reg <= 8'd0;
         gap_cnt_reg  <= '0;
         cs_n_reg     <= 1'b1;
         rd_data_reg  <= 8'h00;
         rd_valid_reg <= 1'b0;
         wr_ready_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (start) begin
            write_reg    <= req_write;
            addr_reg     <= req_addr;
            byte_cnt_reg <= req_len;
            addr_idx_reg <= 2'(ADDR_BYTES - 1);
            cs_n_reg     <= 1'b0;
         end
         if (state_reg == ST_ADDR && byte_end && addr_idx_reg != 2'd0) begin
            addr_idx_reg <= addr_idx_reg - 2'd1;
         end
         // byte_cnt counts remaining bytes down, so len=255 never wraps.
         if (state_reg == ST_DATA && byte_end) begin
            if (byte_cnt_reg == 8'd0) begin
               cs_n_reg <= 1'b1;
            end else begin
               byte_cnt_reg <= byte_cnt_reg - 8'd1;
            end
         end
         gap_cnt_reg  <= (state_reg == ST_GAP) ? gap_cnt_reg + 1'b1 : '0;
         wr_ready_reg <= wr_load;
         rd_valid_reg <= last_sample && (state_reg == ST_DATA) && !write_reg;
         if (last_sample && (state_reg == ST_DATA) && !write_reg) begin
            rd_data_reg <= rx_next;
         end
      end
   end

   assign req_ready = (state_reg == ST_IDLE);
   assign busy      = (state_reg != ST_IDLE);
   assign spi_cs_n  = cs_n_reg;
   assign rd_data   = rd_data_reg;
   assign rd_valid  = rd_valid_reg;
   assign wr_ready  = wr_ready_reg;

endmodule

// File: tb/tb_spi_mem_master.sv
// Directed bench: two configurations share one behavioural SPI RAM through
// a pin mux; sel picks which instance is exercised.
module tb_spi_mem_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, sel, rv, req_write, miso;
   logic [15:0] req_addr;
   logic [7:0]  req_len, wr_data;

   logic       rdy0, wrr0, rdv0, busy0, cs0, sck0, mosi0;
   logic [7:0] rdd0;
   logic       rdy1, wrr1, rdv1, busy1, cs1, sck1, mosi1;
   logic [7:0] rdd1;
   logic       rdy_m, wrr_m, rdv_m, busy_m, cs_m, sck_m, mosi_m;
   logic [7:0] rdd_m;

   spi_mem_master #(.ADDR_BYTES(1), .CLK_DIV(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .req_valid(rv & ~sel), .req_ready(rdy0),
      .req_write(req_write), .req_addr(req_addr[7:0]), .req_len(req_len),
      .wr_data(wr_data), .wr_ready(wrr0), .rd_data(rdd0), .rd_valid(rdv0),
      .busy(busy0), .spi_cs_n(cs0), .spi_sck(sck0), .spi_mosi(mosi0),
      .spi_miso(miso)
   );

   spi_mem_master #(.ADDR_BYTES(2), .CLK_DIV(3)) dut1 (
      .clk(clk), .rst_n(rst_n), .req_valid(rv & sel), .req_ready(rdy1),
      .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
      .wr_data(wr_data), .wr_ready(wrr1), .rd_data(rdd1), .rd_valid(rdv1),
      .busy(busy1), .spi_cs_n(cs1), .spi_sck(sck1), .spi_mosi(mosi1),
      .spi_miso(miso)
   );

   assign rdy_m  = sel ? rdy1  : rdy0;
   assign wrr_m  = sel ? wrr1  : wrr0;
   assign rdv_m  = sel ? rdv1  : rdv0;
   assign busy_m = sel ? busy1 : busy0;
   assign cs_m   = sel ? cs1   : cs0;
   assign sck_m  = sel ? sck1  : sck0;
   assign mosi_m = sel ? mosi1 : mosi0;
   assign rdd_m  = sel ? rdd1  : rdd0;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Behavioural SPI RAM, mode 0, with a fixed power-up pattern.
   logic [7:0]  mem [256];
   bit          written [256];
   logic [7:0]  sh, cmd, out_byte;
   logic [15:0] maddr;
   logic        rd_phase;
   int          bitn, bytn, ab;
   logic [7:0]  mosi_log [64];
   int          mosi_cnt = 0;

   function automatic logic [7:0] mem_rd(input logic [7:0] a);
      if (written[a]) return mem[a];
      case (a)
         8'h00:   return 8'h10;
         8'h01:   return 8'h64;
         8'h02:   return 8'h68;
         8'h03:   return 8'h53;
         default: return a ^ 8'h5A;
      endcase
   endfunction

   always @(posedge sck_m or posedge cs_m) begin
      if (cs_m) begin
         bitn = 0; bytn = 0; rd_phase = 1'b0;
      end else begin
         ab = sel ? 2 : 1;
         sh = {sh[6:0], mosi_m};
         bitn++;
         if (bitn == 8) begin
            bitn = 0;
            mosi_log[mosi_cnt % 64] = sh;
            mosi_cnt++;
            if (bytn == 0) cmd = sh;
            else if (bytn <= ab) maddr = {maddr[7:0], sh};
            else begin
               if (cmd == 8'h02) begin
                  mem[maddr[7:0]] = sh;
                  written[maddr[7:0]] = 1'b1;
               end
               maddr++;
            end
            bytn++;
            if (bytn > ab && cmd == 8'h03) begin
               rd_phase = 1'b1;
               out_byte = mem_rd(maddr[7:0]);
            end
         end
      end
   end

   always @(negedge sck_m or posedge cs_m) begin
      if (cs_m) miso = 1'b0;
      else      miso = rd_phase ? out_byte[7-bitn] : 1'b0;
   end

   // Output monitor, sampled away from the active edge.
   logic [7:0] rd_log [1024];
   int   rd_cnt = 0, wr_cnt = 0, cs_falls = 0, sck_rises = 0;
   logic cs_prev = 1'b1, sck_prev = 1'b0;

   always @(negedge clk) begin
      if (rdv_m) begin
         rd_log[rd_cnt % 1024] = rdd_m;
         rd_cnt++;
      end
      if (wrr_m) wr_cnt++;
      if (cs_prev && !cs_m) cs_falls++;
      if (!sck_prev && sck_m) sck_rises++;
      cs_prev  = cs_m;
      sck_prev = sck_m;
   end

   logic [7:0] wbuf [256];

   task automatic run_txn(input logic w, input logic [15:0] a, input logic [7:0] len,
                          input logic hold);
      int guard;
      $display("txn inst=%0d %s addr=%h len=%0d", sel, w ? "WRITE" : "READ", a, len);
      @(negedge clk);
      req_write = w; req_addr = a; req_len = len; wr_data = wbuf[0]; rv = 1'b1;
      @(negedge clk);
      if (!hold) rv = 1'b0;
      chk("accept_busy_ready", 32'({busy_m, rdy_m}), 32'h2);
      if (w) begin
         for (int i = 0; i <= int'(len); i++) begin
            wr_data = wbuf[i];
            guard = 0;
            while (!wrr_m && guard < 2000) begin
               @(negedge clk);
               guard++;
            end
            if (guard >= 2000) chk("wr_ready_timeout", 32'(guard), 32'd0);
            @(negedge clk);
         end
      end
      guard = 0;
      while (busy_m && guard < 20000) begin
         if (hold && cs_m) rv = 1'b0;
         @(negedge clk);
         guard++;
      end
      rv = 1'b0;
      chk("txn_done", 32'(guard < 20000), 32'd1);
   endtask

   task automatic measure_div();
      int n, g;
      g = 0;
      while (cs_m && g < 200) begin @(negedge clk); g++; end
      n = 0;
      while (!sck_m && n < 50) begin n++; @(negedge clk); end
      chk("div_cs_to_sck", 32'(n), 32'd3);
      n = 0;
      while (sck_m && n < 50) begin n++; @(negedge clk); end
      chk("div_sck_high", 32'(n), 32'd3);
      n = 0;
      while (!sck_m && n < 50) begin n++; @(negedge clk); end
      chk("div_sck_low", 32'(n), 32'd3);
      g = 0;
      while (!cs_m && g < 2000) begin @(negedge clk); g++; end
      n = 0;
      while (cs_m && busy_m && n < 50) begin n++; @(negedge clk); end
      chk("div_gap", 32'(n), 32'd6);
   endtask

   function automatic logic [7:0] exp_mem(input int a);
      case (a)
         0:       return 8'h10;
         1:       return 8'h64;
         2:       return 8'h68;
         3:       return 8'h53;
         32:      return 8'hA5;
         33:      return 8'h3C;
         default: return 8'(a) ^ 8'h5A;
      endcase
   endfunction

   initial begin
      int b, m, w, c, g;
      logic [7:0] exp_a [4];
      exp_a[0] = 8'h10; exp_a[1] = 8'h64; exp_a[2] = 8'h68; exp_a[3] = 8'h53;
      rst_n = 1'b0; sel = 1'b0; rv = 1'b0; req_write = 1'b0;
      req_addr = 16'h0; req_len = 8'h0; wr_data = 8'h0;
      repeat (3) @(negedge clk);
      chk("rst_pins0", 32'({cs0, sck0, mosi0, rdv0, wrr0, busy0, rdy0}), 32'h41);
      chk("rst_rdata0", 32'(rdd0), 32'h0);
      chk("rst_pins1", 32'({cs1, sck1, mosi1, rdv1, wrr1, busy1, rdy1}), 32'h41);
      rst_n = 1'b1;
      @(negedge clk);

      // Read of the preloaded bytes
      b = rd_cnt; m = mosi_cnt;
      run_txn(1'b0, 16'h0000, 8'd3, 1'b0);
      chk("rd4_count", 32'(rd_cnt - b), 32'd4);
      for (int i = 0; i < 4; i++) chk("rd4_data", 32'(rd_log[(b + i) % 1024]), 32'(exp_a[i]));
      chk("rd4_mosi_cmd", 32'(mosi_log[m % 64]), 32'h03);
      chk("rd4_mosi_addr", 32'(mosi_log[(m + 1) % 64]), 32'h00);
      chk("rd4_mosi_data_zero", 32'(mosi_log[(m + 2) % 64]), 32'h00);
      chk("rd4_busy_low", 32'(busy_m), 32'd0);

      // Write two bytes then read them back
      wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
      b = rd_cnt; m = mosi_cnt; w = wr_cnt;
      run_txn(1'b1, 16'h0020, 8'd1, 1'b0);
      chk("wr_ready_count", 32'(wr_cnt - w), 32'd2);
      chk("wr_no_rd_valid", 32'(rd_cnt - b), 32'd0);
      chk("wr_mosi_cmd", 32'(mosi_log[m % 64]), 32'h02);
      chk("wr_mosi_addr", 32'(mosi_log[(m + 1) % 64]), 32'h20);
      chk("wr_mosi_d0", 32'(mosi_log[(m + 2) % 64]), 32'hA5);
      chk("wr_mosi_d1", 32'(mosi_log[(m + 3) % 64]), 32'h3C);
      b = rd_cnt;
      run_txn(1'b0, 16'h0020, 8'd1, 1'b0);
      chk("rdback_count", 32'(rd_cnt - b), 32'd2);
      chk("rdback_d0", 32'(rd_log[b % 1024]), 32'hA5);
      chk("rdback_d1", 32'(rd_log[(b + 1) % 1024]), 32'h3C);

      // Two-byte address, CLK_DIV=3 instance
      @(negedge clk);
      sel = 1'b1;
      b = rd_cnt; m = mosi_cnt;
      fork
         run_txn(1'b0, 16'h1234, 8'd1, 1'b0);
         measure_div();
      join
      chk("a2_mosi_cmd", 32'(mosi_log[m % 64]), 32'h03);
      chk("a2_mosi_hi", 32'(mosi_log[(m + 1) % 64]), 32'h12);
      chk("a2_mosi_lo", 32'(mosi_log[(m + 2) % 64]), 32'h34);
      chk("a2_count", 32'(rd_cnt - b), 32'd2);
      chk("a2_d0", 32'(rd_log[b % 1024]), 32'h6E);
      chk("a2_d1", 32'(rd_log[(b + 1) % 1024]), 32'h6F);
      @(negedge clk);
      sel = 1'b0;

      // Reset in the middle of the first data byte
      $display("txn inst=0 READ addr=0000 len=3 aborted by reset");
      b = rd_cnt; c = sck_rises;
      @(negedge clk);
      req_write = 1'b0; req_addr = 16'h0; req_len = 8'd3; rv = 1'b1;
      @(negedge clk);
      rv = 1'b0;
      g = 0;
      while ((sck_rises - c) < 21 && g < 500) begin @(negedge clk); g++; end
      chk("abort_reach_bit5", 32'(g < 500), 32'd1);
      #2 rst_n = 1'b0;
      #1 chk("abort_pins", 32'({cs_m, sck_m, mosi_m, busy_m}), 32'h8);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("abort_no_rd_valid", 32'(rd_cnt - b), 32'd0);
      b = rd_cnt;
      run_txn(1'b0, 16'h0002, 8'd1, 1'b0);
      chk("post_abort_count", 32'(rd_cnt - b), 32'd2);
      chk("post_abort_d0", 32'(rd_log[b % 1024]), 32'h68);
      chk("post_abort_d1", 32'(rd_log[(b + 1) % 1024]), 32'h53);

      // 256-byte read with req_valid held high
      b = rd_cnt; c = cs_falls;
      run_txn(1'b0, 16'h0000, 8'd255, 1'b1);
      chk("long_cs_falls", 32'(cs_falls - c), 32'd1);
      chk("long_count", 32'(rd_cnt - b), 32'd256);
      for (int i = 0; i < 256; i++)
         chk("long_data", 32'(rd_log[(b + i) % 1024]), 32'(exp_mem(i)));
      repeat (4) @(negedge clk);
      chk("long_no_requeue", 32'({busy_m, 8'(cs_falls - c)}), 32'h001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
